mac_node: RTL and testbench

- Parametrised successor to the single-product neural network node.
- Accepts a streamed vector of NUM_IN signed fixed-point inputs with matching coefficients, LANES products per accepted beat.
- Adds a preloaded bias, saturates, and applies a run-time selectable activation.
- Sits between the image/coefficient buffers and the layer controller: valid/ready on input and output, sticky saturation flag.

---
 rtl/mac_node.sv | 168 ++++++++++++++++
 tb/tb_mac_node.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_node.sv
// Multi-lane MAC neuron: bias + sum(coef*data) over NUM_IN inputs, saturate, activate.
// Latency: NUM_IN/LANES accepted beats + 2 cycles from start to out_valid.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
module mac_node #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int NUM_IN = 64,
    parameter int LANES  = 4,
    parameter int ACC_W  = 40
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                act_mode,
    input  logic [DATA_W-1:0]         bias,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   coef_in,
    input  logic [LANES*DATA_W-1:0]   data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         node_out,
    output logic                      sat_flag,
    output logic                      busy
);

    localparam int BEATS  = NUM_IN / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    // Headroom so the accumulator plus one beat of products can never wrap.
    localparam int WIDE_W = ACC_W + PROD_W + $clog2(LANES) + 1;
    localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]        DAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]        DAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W:0]   HS_HALF   = (DATA_W+1)'(1 << (FRAC_W - 1));
    localparam logic signed [DATA_W:0]   HS_ONE    = (DATA_W+1)'(1 << FRAC_W);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic [BEAT_W-1:0]        beat_q;
    logic [1:0]               mode_q;
    logic                     do_init, do_step, do_act, do_clear;

    // Full-precision signed lane product, sign-extended into the wide adder.
    function automatic logic signed [WIDE_W-1:0] lane_prod(input logic [DATA_W-1:0] a,
                                                            input logic [DATA_W-1:0] b);
        logic signed [PROD_W-1:0] ae, be, p;
        ae = {{DATA_W{a[DATA_W-1]}}, a};
        be = {{DATA_W{b[DATA_W-1]}}, b};
        p  = ae * be;
        return {{(WIDE_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    logic signed [WIDE_W-1:0]  beat_sum, acc_sum;
    logic [WIDE_W-ACC_W:0]     acc_top;
    logic                      acc_ovf;
    logic signed [ACC_W-1:0]   acc_next, x_full;
    logic [ACC_W-DATA_W:0]     x_top;
    logic                      x_ovf;
    logic [DATA_W-1:0]         x_sat, act_y;
    logic signed [DATA_W:0]    x_ext, hs;

    // Sum this beat's lane products and fold into the accumulator with clamping.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + lane_prod(coef_in[k*DATA_W +: DATA_W], data_in[k*DATA_W +: DATA_W]);
        end
        acc_sum  = {{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q} + beat_sum;
        acc_top  = acc_sum[WIDE_W-1:ACC_W-1];
        acc_ovf  = !((&acc_top) || (~|acc_top));
        acc_next = acc_ovf ? (acc_sum[WIDE_W-1] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];
    end

    // Rescale to DATA_W with saturation, then apply the latched activation.
    always_comb begin
        x_full = acc_q >>> FRAC_W;
        x_top  = x_full[ACC_W-1:DATA_W-1];
        x_ovf  = !((&x_top) || (~|x_top));
        x_sat  = x_ovf ? (x_full[ACC_W-1] ? DAT_MIN : DAT_MAX) : x_full[DATA_W-1:0];
        x_ext  = {x_sat[DATA_W-1], x_sat};
        hs     = (x_ext >>> 2) + HS_HALF;
        case (mode_q)
            2'd1:    act_y = x_sat[DATA_W-1] ? '0 : x_sat;
            2'd2: begin
                if (hs[DATA_W])       act_y = '0;
                else if (hs > HS_ONE) act_y = HS_ONE[DATA_W-1:0];
                else                  act_y = hs[DATA_W-1:0];
            end
            default: act_y = x_sat;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath strobes; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        do_init  = 1'b0;
        do_step  = 1'b0;
        do_act   = 1'b0;
        do_clear = 1'b0;
        if (abort) begin
            state_d  = S_IDLE;
            do_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d = S_ACCUM;
                    do_init = 1'b1;
                end
                S_ACCUM: if (in_valid) begin
                    do_step = 1'b1;
                    if (beat_q == LAST_BEAT) state_d = S_ACT;
                end
                S_ACT: begin
                    do_act  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: if (out_ready) begin
                    state_d = start ? S_ACCUM : S_IDLE;
                    do_init = start;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Accumulator, beat counter, latched mode, result and sticky saturation.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q    <= '0;
            beat_q   <= '0;
            mode_q   <= '0;
            node_out <= '0;
            sat_flag <= 1'b0;
        end else if (do_clear) begin
            acc_q  <= '0;
            beat_q <= '0;
        end else if (do_init) begin
            acc_q    <= {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
            beat_q   <= '0;
            mode_q   <= act_mode;
            sat_flag <= 1'b0;
        end else if (do_step) begin
            acc_q    <= acc_next;
            beat_q   <= beat_q + 1'b1;
            sat_flag <= sat_flag | acc_ovf;
        end else if (do_act) begin
            node_out <= act_y;
            sat_flag <= sat_flag | x_ovf;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_node.sv
// Scoreboard bench for mac_node with NUM_IN=8, LANES=4 (two beats per evaluation).
module tb_mac_node;

    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int NIN   = 8;
    localparam int BEATS = NIN / LANES;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]        act_mode = '0;
    logic [DW-1:0]     bias = '0;
    logic [LANES*DW-1:0] coef_in = '0, data_in = '0;
    logic              in_ready, out_valid, sat_flag, busy;
    logic [DW-1:0]     node_out;

    mac_node #(.DATA_W(DW), .FRAC_W(8), .NUM_IN(NIN), .LANES(LANES), .ACC_W(40)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .act_mode(act_mode),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .coef_in(coef_in),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .node_out(node_out), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    int vectors = 0;
    int miscompares = 0;
    int st = 0;
    logic [16:0] sb_q[$];
    logic signed [DW-1:0] cf [BEATS][LANES];
    logic signed [DW-1:0] dt [BEATS][LANES];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Independent arithmetic reference: {sat, y}.
    function automatic logic [16:0] model(input logic [1:0] m, input logic [DW-1:0] bs);
        longint amax = (longint'(1) <<< 39) - 1;
        longint amin = -(longint'(1) <<< 39);
        longint acc, bsum, x, h;
        bit s = 0;
        acc = longint'($signed(bs)) * 256;
        for (int b = 0; b < BEATS; b++) begin
            bsum = 0;
            for (int k = 0; k < LANES; k++) bsum += longint'(cf[b][k]) * longint'(dt[b][k]);
            acc += bsum;
            if (acc > amax) begin acc = amax; s = 1; end
            if (acc < amin) begin acc = amin; s = 1; end
        end
        x = acc >>> 8;
        if (x > 32767)  begin x = 32767;  s = 1; end
        if (x < -32768) begin x = -32768; s = 1; end
        if (m == 2'd1 && x < 0) x = 0;
        if (m == 2'd2) begin
            h = (x >>> 2) + 128;
            if (h < 0)   h = 0;
            if (h > 256) h = 256;
            x = h;
        end
        return {s, 16'(x)};
    endfunction

    task automatic set_all(input logic [DW-1:0] c, input logic [DW-1:0] d);
        for (int b = 0; b < BEATS; b++)
            for (int k = 0; k < LANES; k++) begin cf[b][k] = c; dt[b][k] = d; end
    endtask

    task automatic rand_all();
        for (int b = 0; b < BEATS; b++)
            for (int k = 0; k < LANES; k++) begin
                cf[b][k] = 16'(int'($urandom_range(1023)) - 512);
                dt[b][k] = 16'(int'($urandom_range(1023)) - 512);
            end
    endtask

    task automatic drive_beat(input int b);
        for (int k = 0; k < LANES; k++) begin
            coef_in[k*DW +: DW] = cf[b][k];
            data_in[k*DW +: DW] = dt[b][k];
        end
    endtask

    // Called at a negedge; leaves the DUT in ACCUM at the next negedge.
    task automatic begin_eval(input logic [1:0] m, input logic [DW-1:0] b, input bit push);
        start = 1'b1; act_mode = m; bias = b;
        if (push) sb_q.push_back(model(m, b));
        st = pcnt;
        @(negedge clk);
        start = 1'b0;
        chk("accum_rdy", in_ready, 1);
        chk("accum_sat_clr", sat_flag, 0);
    endtask

    task automatic feed(input int gap_pct);
        int  b = 0;
        int  cyc = 0;
        bit  take;
        while (b < BEATS && cyc < 200) begin
            take = in_ready && (int'($urandom_range(99)) >= gap_pct);
            if (take) begin in_valid = 1'b1; drive_beat(b); end
            else        in_valid = 1'b0;
            @(negedge clk);
            cyc++;
            if (take) b++;
        end
        in_valid = 1'b0;
        if (b != BEATS) chk("feed_timeout", b, BEATS);
    endtask

    task automatic collect(input int hold, input bit b2b, input logic [1:0] m2,
                           input logic [DW-1:0] b2, input bit chk_lat);
        int w = 0;
        logic [16:0] e;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        chk("out_vld", out_valid, 1);
        if (chk_lat) chk("latency", pcnt - st, BEATS + 2);
        if (sb_q.size() == 0) begin
            chk("sb_empty", sb_q.size(), 1);
            return;
        end
        e = sb_q.pop_front();
        chk("node_out", node_out, e[15:0]);
        chk("sat_flag", sat_flag, e[16]);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_vld", out_valid, 1);
            chk("hold_out", node_out, e[15:0]);
        end
        out_ready = 1'b1;
        if (b2b) begin
            start = 1'b1; act_mode = m2; bias = b2;
            sb_q.push_back(model(m2, b2));
            st = pcnt;
        end
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        chk("post_hs_vld", out_valid, 0);
        if (b2b) chk("b2b_rdy", in_ready, 1);
        else     chk("idle_busy", busy, 0);
    endtask

    initial begin
        #2;
        chk("rst_out", node_out, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Basic linear with latency check.
        set_all(16'h0100, 16'h0080);
        begin_eval(2'd0, 16'h0000, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 1);

        // Negative products: ReLU then linear.
        set_all(16'hFF00, 16'h0100);
        begin_eval(2'd1, 16'h0000, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 1);
        begin_eval(2'd0, 16'h0000, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 1);

        // Hard-sigmoid driven purely by bias.
        set_all(16'h0100, 16'h0000);
        begin_eval(2'd2, 16'h0000, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 0);
        begin_eval(2'd2, 16'h0400, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 0);
        begin_eval(2'd2, 16'hFC00, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 0);

        // Output saturation, then a clean evaluation clears the flag.
        set_all(16'h7FFF, 16'h7FFF);
        begin_eval(2'd0, 16'h0000, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 0);
        set_all(16'h0100, 16'h0080);
        begin_eval(2'd0, 16'h0000, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 0);

        // Random data, input gaps, held output, back-to-back restart.
        rand_all();
        begin_eval(2'd0, 16'(int'($urandom_range(2047)) - 1024), 1);
        feed(40);
        rand_all();
        collect(5, 1, 2'd1, 16'(int'($urandom_range(2047)) - 1024), 0);
        feed(30);
        collect(0, 0, 2'd0, 16'h0, 0);

        // Abort after the first beat; the next evaluation must start clean.
        set_all(16'h0100, 16'h0100);
        begin_eval(2'd0, 16'h0000, 0);
        in_valid = 1'b1; drive_beat(0);
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_vld", out_valid, 0);
        chk("abort_rdy", in_ready, 0);
        begin_eval(2'd0, 16'h0000, 1); feed(0); collect(0, 0, 2'd0, 16'h0, 0);

        // Async reset mid-accumulation.
        begin_eval(2'd0, 16'h0000, 0);
        in_valid = 1'b1; drive_beat(0);
        @(negedge clk);
        in_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_out", node_out, 0);
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_sat", sat_flag, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
